// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and constants for the radix-4 Booth multiplier
//
// Contents:
//   DEFAULT_WIDTH  default operand width
//   mul_state_t    controller states (IDLE, RUN, DONE)
//   booth_digit_t  recoded radix-4 Booth digit (ZERO, POS1, POS2, NEG1, NEG2)
package mul_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mul_state_t;

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } booth_digit_t;

endpackage

// File: rtl/booth_mul_if.sv
// rtl/booth_mul_if.sv - request/result bundle between a requester and booth_mul
//
// Signals:
//   start  request a multiply (sampled on the rising clock edge)
//   M, Q   signed multiplicand / multiplier
//   busy   operation in progress
//   done   one-cycle pulse, hi/lo valid
//   hi, lo upper / lower halves of the 2*WIDTH-bit product
// Modports: master drives the request side, slave is the multiplier.
interface booth_mul_if
    import mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] M;
    logic [WIDTH-1:0] Q;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, M, Q,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, M, Q,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/booth_recoder.sv
// rtl/booth_recoder.sv - combinational radix-4 Booth digit selection
//
// Ports:
//   window  {q[2i+1], q[2i], q[2i-1]} multiplier bit window
//   digit   selected multiple of M: 0, +1, +2, -1 or -2
module booth_recoder
    import mul_pkg::*;
(
    input  logic [2:0]   window,
    output booth_digit_t digit
);

    // Digit value is -2*w[2] + w[1] + w[0].
    always_comb begin
        digit = ZERO;
        case (window)
            3'b001,
            3'b010:  digit = POS1;
            3'b011:  digit = POS2;
            3'b100:  digit = NEG2;
            3'b101,
            3'b110:  digit = NEG1;
            default: digit = ZERO;
        endcase
    end

endmodule

// File: rtl/booth_mul.sv
// rtl/booth_mul.sv - sequential signed multiplier, radix-4 Booth, WIDTH/2 steps
//
// Ports:
//   clk    single clock, rising edge
//   reset  asynchronous, active-high
//   bus    booth_mul_if.slave: start/M/Q in, busy/done/hi/lo out
// Latency: start accepted at edge N, done high during the cycle after edge
// N+WIDTH/2. Start is ignored while busy and accepted in DONE (back-to-back).
module booth_mul
    import mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
)(
    input  logic        clk,
    input  logic        reset,
    booth_mul_if.slave  bus
);

    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
        $error("booth_mul: WIDTH must be even and at least 4");
    end

    localparam int STEPS = WIDTH / 2;
    localparam int CNT_W = $clog2(STEPS + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    mul_state_t       state;
    logic [CNT_W-1:0] step_cnt;
    logic [WIDTH+1:0] acc;      // upper partial product, two guard bits
    logic [WIDTH-1:0] m_reg;    // captured multiplicand
    logic [WIDTH-1:0] q_reg;    // multiplier, refilled from the bottom of acc
    logic             q_m1;     // q[-1]: last bit shifted out of q_reg
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    booth_digit_t     digit;
    logic [WIDTH+1:0] m_x1;
    logic [WIDTH+1:0] m_x2;
    logic [WIDTH+1:0] acc_sum;

    booth_recoder u_recoder (
        .window ({q_reg[1], q_reg[0], q_m1}),
        .digit  (digit)
    );

    // Sign-extended +M and +2M; two guard bits keep +/-2M of the most
    // negative operand representable.
    assign m_x1 = {{2{m_reg[WIDTH-1]}}, m_reg};
    assign m_x2 = {m_reg[WIDTH-1], m_reg, 1'b0};

    always_comb begin
        acc_sum = acc;
        case (digit)
            POS1:    acc_sum = acc + m_x1;
            POS2:    acc_sum = acc + m_x2;
            NEG1:    acc_sum = acc - m_x1;
            NEG2:    acc_sum = acc - m_x2;
            default: acc_sum = acc;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            step_cnt <= '0;
            acc      <= '0;
            m_reg    <= '0;
            q_reg    <= '0;
            q_m1     <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            hi_r     <= '0;
            lo_r     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        state    <= RUN;
                        busy_r   <= 1'b1;
                        m_reg    <= bus.M;
                        q_reg    <= bus.Q;
                        q_m1     <= 1'b0;
                        acc      <= '0;
                        step_cnt <= '0;
                    end
                end

                RUN: begin
                    // Add the selected multiple, then shift {acc, q, q_m1}
                    // right arithmetically by two.
                    acc      <= {{2{acc_sum[WIDTH+1]}}, acc_sum[WIDTH+1:2]};
                    q_reg    <= {acc_sum[1:0], q_reg[WIDTH-1:2]};
                    q_m1     <= q_reg[1];
                    step_cnt <= step_cnt + CNT_W'(1);
                    if (step_cnt == LAST_STEP) begin
                        // Result is taken from the post-shift value so it is
                        // ready in the same edge that enters DONE.
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        hi_r   <= acc_sum[WIDTH+1:2];
                        lo_r   <= {acc_sum[1:0], q_reg[WIDTH-1:2]};
                    end
                end

                DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        state    <= RUN;
                        busy_r   <= 1'b1;
                        m_reg    <= bus.M;
                        q_reg    <= bus.Q;
                        q_m1     <= 1'b0;
                        acc      <= '0;
                        step_cnt <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

endmodule
